// File: rtl/mandelbrot_pixel_packer.sv
// mandelbrot_pixel_packer: paces the Mandelbrot engine one pixel at a time, packs two
// 4-bit iteration codes per byte and streams the bytes out through a small FIFO.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : frame request, accepted only when idle and the engine is finished
//   engine_running/finished, pixel_code : engine status and iteration code
//   run                : one-cycle per-pixel kick to the engine
//   out_data/sof/eol/valid, out_ready   : packed byte stream with frame/line tags
//   busy, frame_done   : frame in progress, one-cycle pulse when the frame has drained
module mandelbrot_pixel_packer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       engine_running,
    input  logic       engine_finished,
    input  logic [3:0] pixel_code,
    output logic       run,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [3:0]      lo_q, lo_d;
    logic            l_run_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic            pixel_done, push, pop;
    logic [9:0]      push_entry, head;

    // The engine updates pixel_code on the same edge that drops running.
    assign pixel_done = l_run_q & ~engine_running;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        lo_d       = lo_q;
        run        = 1'b0;
        push       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: if (start && engine_finished) begin
                state_d = S_ISSUE;
                x_d     = '0;
                y_d     = '0;
                lo_d    = '0;
            end
            // A free FIFO slot is reserved before the pixel starts, so the push can never overflow.
            S_ISSUE: begin
                run     = count_q < DEPTH_C;
                state_d = run ? S_WAIT : S_ISSUE;
            end
            S_WAIT: if (pixel_done) begin
                lo_d    = x_q[0] ? lo_q : pixel_code;
                push    = x_q[0];
                x_d     = (x_q == X_LAST) ? '0 : x_q + 1'b1;
                y_d     = (x_q == X_LAST) ? y_q + 1'b1 : y_q;
                state_d = (x_q == X_LAST && y_q == Y_LAST) ? S_FLUSH : S_ISSUE;
            end
            S_FLUSH: if (count_q == '0) begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push_entry = {pixel_code, lo_q, (x_q == XW'(1)) && (y_q == '0), x_q == X_LAST};
    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = count_q != '0;
    assign pop        = out_valid & out_ready;
    assign out_data   = out_valid ? head[9:2] : 8'h00;
    assign out_sof    = out_valid & head[1];
    assign out_eol    = out_valid & head[0];
    assign busy       = state_q != S_IDLE;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            lo_q     <= '0;
            l_run_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            lo_q     <= lo_d;
            l_run_q  <= engine_running;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end
endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// tb_mandelbrot_pixel_packer: scoreboard bench with a behavioural engine and a frame-level reference model.
module tb_mandelbrot_pixel_packer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 4;
    localparam int NB = W * H / 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic eng_run = 1'b0, eng_fin = 1'b1, fin_block = 1'b0;
    logic [3:0] pixel_code = 4'h0;
    logic engine_finished;
    logic run, out_sof, out_eol, out_valid, busy, frame_done;
    logic [7:0] out_data;

    int n_tests = 0, n_fail = 0;
    int run_cnt = 0, pix_cnt = 0, fd_cnt = 0, rx_cnt = 0, sof_cnt = 0, eol_cnt = 0;
    int full_push = 0, max_count = 0;
    bit rdy_toggle = 0, rdy_val = 0, lat_rand = 0;
    logic [9:0] exp_q[$];
    logic [3:0] eng_q[$];

    assign engine_finished = eng_fin & ~fin_block;

    mandelbrot_pixel_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .engine_running(eng_run), .engine_finished(engine_finished), .pixel_code(pixel_code),
        .run(run), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int f0;
        int i;
        f0 = fd_cnt;
        i = 0;
        while (fd_cnt == f0 && i < 5000) begin
            tick(1);
            i++;
        end
        check(name, int'(fd_cnt != f0), 1);
    endtask

    // Reference: a frame is a raster of codes; byte p holds pixels 2p (low) and 2p+1 (high).
    task automatic load_frame(input bit ordered);
        logic [3:0] c [W*H];
        for (int i = 0; i < W * H; i++) begin
            c[i] = ordered ? 4'(i + 1) : 4'($urandom_range(0, 15));
            eng_q.push_back(c[i]);
        end
        for (int p = 0; p < NB; p++)
            exp_q.push_back({c[2*p+1], c[2*p], p == 0, ((2 * p) % W) + 2 == W});
    endtask

    // Behavioural engine: sees run, computes for lat cycles, drops running with the code.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (run && rst_n) begin
                lat = lat_rand ? int'($urandom_range(1, 20)) : 3;
                @(posedge clk);
                #1 eng_run = 1'b1;
                eng_fin = 1'b0;
                repeat (lat) @(posedge clk);
                #1 eng_run = 1'b0;
                eng_fin = 1'b1;
                pixel_code = (eng_q.size() != 0) ? eng_q.pop_front() : 4'h0;
                pix_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = rdy_toggle ? ~out_ready : rdy_val;
        end
    end

    // Monitor: pops the scoreboard on each accepted byte, checks stalls hold the head.
    initial begin
        logic [9:0] held;
        logic [9:0] e;
        bit hold;
        hold = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 0;
            else begin
                if (run) run_cnt++;
                if (frame_done) fd_cnt++;
                if (int'(dut.count_q) > max_count) max_count = int'(dut.count_q);
                if (dut.push && int'(dut.count_q) == D) full_push++;
                if (hold)
                    check("hold_stable", int'({out_valid, out_data, out_sof, out_eol}), int'({1'b1, held}));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("byte", int'({out_data, out_sof, out_eol}), int'(e));
                        rx_cnt++;
                        sof_cnt += int'(out_sof);
                        eol_cnt += int'(out_eol);
                    end
                end
                hold = out_valid && !out_ready;
                held = {out_data, out_sof, out_eol};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, p0, f0, b0, s0, e0;
        #1;
        check("rst_run", int'(run), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_sof", int'(out_sof), 0);
        check("rst_eol", int'(out_eol), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        fin_block = 1'b1;
        r0 = run_cnt;
        pulse_start();
        tick(5);
        check("start_unfinished_busy", int'(busy), 0);
        check("start_unfinished_run", run_cnt - r0, 0);
        fin_block = 1'b0;

        rdy_val = 1;
        tick(1);
        load_frame(1);
        r0 = run_cnt;
        f0 = fd_cnt;
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        tick(3);
        pulse_start();
        wait_fd("frame1_done");
        check("frame1_busy_low", int'(busy), 0);
        check("frame1_runs", run_cnt - r0, W * H);
        tick(3);
        check("frame1_single_done", fd_cnt - f0, 1);
        check("frame1_all_bytes", exp_q.size(), 0);

        rdy_val = 0;
        tick(1);
        load_frame(1);
        p0 = pix_cnt;
        r0 = run_cnt;
        f0 = fd_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && pix_cnt - p0 < W * H; i++) tick(1);
        tick(4);
        check("stall_runs", run_cnt - r0, W * H);
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), 8'h21);
        check("stall_sof", int'(out_sof), 1);
        check("stall_busy", int'(busy), 1);
        check("stall_no_done", fd_cnt - f0, 0);
        check("stall_fifo_full", max_count, D);
        tick(10);
        check("stall_data_held", int'(out_data), 8'h21);
        rdy_val = 1;
        wait_fd("stall_frame_done");
        check("stall_all_bytes", exp_q.size(), 0);

        rdy_val = 0;
        tick(1);
        load_frame(0);
        p0 = pix_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && pix_cnt - p0 < 3; i++) tick(1);
        tick(1);
        check("pre_reset_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_run", int'(run), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_sof", int'(out_sof), 0);
        check("midrst_eol", int'(out_eol), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && !(eng_fin && !eng_run); i++) tick(1);
        tick(2);
        exp_q.delete();
        eng_q.delete();
        rdy_val = 1;
        tick(1);
        load_frame(0);
        pulse_start();
        wait_fd("post_reset_done");
        check("post_reset_all_bytes", exp_q.size(), 0);

        rdy_toggle = 1;
        lat_rand = 1;
        b0 = rx_cnt;
        s0 = sof_cnt;
        e0 = eol_cnt;
        for (int f = 0; f < 20; f++) begin
            load_frame(0);
            pulse_start();
            wait_fd("rand_frame_done");
            tick(int'($urandom_range(0, 3)));
        end
        rdy_toggle = 0;
        check("rand_bytes", rx_cnt - b0, 20 * NB);
        check("rand_sof", sof_cnt - s0, 20);
        check("rand_eol", eol_cnt - e0, 20 * H);
        check("rand_all_bytes", exp_q.size(), 0);
        check("fifo_max_count", max_count, D);
        check("push_while_full", full_push, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
